// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths and port index type for the SRAM port arbiter
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_idx_e;

  // Round-robin hand-off: the port that just won yields priority to the other one.
  function automatic port_idx_e other_port(input port_idx_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sram_arb_rsp_skid.sv
// rtl/sram_arb_rsp_skid.sv - per-port read response path: in-flight flag, one-entry hold, bypass mux
module sram_arb_rsp_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_grant,
  input  logic              rsp_ready,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rd_eligible
);

  logic              inflight;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  // The macro returns data exactly one cycle after the access; capture it only if the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      inflight <= rd_grant;
      if (inflight && !rsp_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= sram_dout;
      end else if (hold_valid && rsp_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Present held data when parked, otherwise bypass the macro output; a new read may issue
  // only when nothing is parked and any in-flight response is being taken this cycle.
  always_comb begin
    rsp_valid   = inflight | hold_valid;
    rsp_rdata   = hold_valid ? hold_data : (inflight ? sram_dout : '0);
    rd_eligible = !hold_valid && (!inflight || rsp_ready);
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port arbiter for a single-port SRAM macro; SRAM_ARB_RR_EN selects round-robin, else port a fixed priority
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid_a,
  output logic              req_ready_a,
  input  logic              req_we_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [DATA_W-1:0] req_wdata_a,
  input  logic [DATA_W-1:0] req_bm_a,
  output logic              rsp_valid_a,
  input  logic              rsp_ready_a,
  output logic [DATA_W-1:0] rsp_rdata_a,
  input  logic              req_valid_b,
  output logic              req_ready_b,
  input  logic              req_we_b,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata_b,
  input  logic [DATA_W-1:0] req_bm_b,
  output logic              rsp_valid_b,
  input  logic              rsp_ready_b,
  output logic [DATA_W-1:0] rsp_rdata_b,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_bm,
  output logic              sram_men,
  output logic              sram_wen,
  output logic              sram_ren,
  input  logic [DATA_W-1:0] sram_dout
);

  logic rd_ok_a, rd_ok_b;
  logic elig_a, elig_b;
  logic gnt_a, gnt_b;

  assign elig_a = req_valid_a && (req_we_a || rd_ok_a);
  assign elig_b = req_valid_b && (req_we_b || rd_ok_b);

`ifdef SRAM_ARB_RR_EN
  port_idx_e ptr;

  // Priority passes to the other port after every grant so continuous contention alternates.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr <= PORT_A;
    end else if (gnt_a || gnt_b) begin
      ptr <= other_port(gnt_a ? PORT_A : PORT_B);
    end
  end
`endif

  // Single grant per cycle; held off during reset so every output reads zero.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (RST_N) begin
      if (elig_a && elig_b) begin
`ifdef SRAM_ARB_RR_EN
        if (ptr == PORT_A) gnt_a = 1'b1;
        else               gnt_b = 1'b1;
`else
        gnt_a = 1'b1;
`endif
      end else begin
        gnt_a = elig_a;
        gnt_b = elig_b;
      end
    end
  end

  assign req_ready_a = gnt_a;
  assign req_ready_b = gnt_b;

  // Steer the winning request onto the macro pins; everything idles at zero without a grant.
  always_comb begin
    sram_men  = 1'b0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    sram_bm   = '0;
    if (gnt_a) begin
      sram_men  = 1'b1;
      sram_addr = req_addr_a;
      sram_wen  = req_we_a;
      sram_ren  = !req_we_a;
      sram_din  = req_we_a ? req_wdata_a : '0;
      sram_bm   = req_we_a ? req_bm_a : '0;
    end else if (gnt_b) begin
      sram_men  = 1'b1;
      sram_addr = req_addr_b;
      sram_wen  = req_we_b;
      sram_ren  = !req_we_b;
      sram_din  = req_we_b ? req_wdata_b : '0;
      sram_bm   = req_we_b ? req_bm_b : '0;
    end
  end

  sram_arb_rsp_skid #(.DATA_W(DATA_W)) u_skid_a (
    .clk        (CLK),
    .rst_n      (RST_N),
    .rd_grant   (gnt_a && !req_we_a),
    .rsp_ready  (rsp_ready_a),
    .sram_dout  (sram_dout),
    .rsp_valid  (rsp_valid_a),
    .rsp_rdata  (rsp_rdata_a),
    .rd_eligible(rd_ok_a)
  );

  sram_arb_rsp_skid #(.DATA_W(DATA_W)) u_skid_b (
    .clk        (CLK),
    .rst_n      (RST_N),
    .rd_grant   (gnt_b && !req_we_b),
    .rsp_ready  (rsp_ready_b),
    .sram_dout  (sram_dout),
    .rsp_valid  (rsp_valid_b),
    .rsp_rdata  (rsp_rdata_b),
    .rd_eligible(rd_ok_b)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter with a behavioural SRAM and reference model
module tb_sram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid_a, req_ready_a, req_we_a;
  logic [9:0]  req_addr_a;
  logic [31:0] req_wdata_a, req_bm_a;
  logic        rsp_valid_a, rsp_ready_a;
  logic [31:0] rsp_rdata_a;
  logic        req_valid_b, req_ready_b, req_we_b;
  logic [9:0]  req_addr_b;
  logic [31:0] req_wdata_b, req_bm_b;
  logic        rsp_valid_b, rsp_ready_b;
  logic [31:0] rsp_rdata_b;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din, sram_bm, sram_dout;
  logic        sram_men, sram_wen, sram_ren;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  sram_port_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
    .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a), .req_bm_a(req_bm_a),
    .rsp_valid_a(rsp_valid_a), .rsp_ready_a(rsp_ready_a), .rsp_rdata_a(rsp_rdata_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
    .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b), .req_bm_b(req_bm_b),
    .rsp_valid_b(rsp_valid_b), .rsp_ready_b(rsp_ready_b), .rsp_rdata_b(rsp_rdata_b),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_dout(sram_dout)
  );

  // Behavioural 1024x32 macro: bit-masked write, registered read data.
  logic [31:0] mem [0:1023];
  always @(posedge CLK) begin
    if (sram_men) begin
      if (sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
      if (sram_ren) sram_dout <= mem[sram_addr];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req_valid_a = 0; req_we_a = 0; req_addr_a = '0; req_wdata_a = '0; req_bm_a = '0;
    req_valid_b = 0; req_we_b = 0; req_addr_b = '0; req_wdata_b = '0; req_bm_b = '0;
  endtask

  task automatic do_reset();
    RST_N = 0;
    idle();
    rsp_ready_a = 1;
    rsp_ready_b = 1;
    tick();
    tick();
    RST_N = 1;
  endtask

  task automatic test_reset();
    do_reset();
    req_valid_a = 1; req_we_a = 0; req_addr_a = 10'd3; rsp_ready_a = 0;
    @(negedge CLK);
    n_cmp++; if (req_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_pre_grant: got %b want 1", req_ready_a); end
    tick();
    idle(); RST_N = 0; req_valid_b = 1;
    @(negedge CLK);
    n_cmp++; if (rsp_valid_a !== 1'b1) begin n_fail++; $display("FAIL reset_inflight_visible: got %b want 1", rsp_valid_a); end
    tick();
    @(negedge CLK);
    n_cmp++; if ({req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b} !== 4'b0) begin
      n_fail++; $display("FAIL reset_handshake_zero: got %b want 0000", {req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b}); end
    n_cmp++; if ({rsp_rdata_a, rsp_rdata_b} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata_zero: got %h want 0", {rsp_rdata_a, rsp_rdata_b}); end
    n_cmp++; if ({sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm} !== 77'h0) begin
      n_fail++; $display("FAIL reset_sram_zero: got %h want 0", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm}); end
    tick();
    RST_N = 1; rsp_ready_a = 1; rsp_ready_b = 1;
    req_valid_a = 1; req_we_a = 0; req_addr_a = 10'd1;
    req_valid_b = 1; req_we_b = 0; req_addr_b = 10'd2;
    @(negedge CLK);
    n_cmp++; if ({req_ready_a, req_ready_b} !== 2'b10) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 10", {req_ready_a, req_ready_b}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    req_valid_a = 1; req_we_a = 1; req_addr_a = 10'd5; req_wdata_a = 32'hDEADBEEF; req_bm_a = 32'hFFFFFFFF;
    @(negedge CLK);
    n_cmp++; if ({req_ready_a, sram_men, sram_wen, sram_ren, sram_addr} !== {4'b1110, 10'd5}) begin
      n_fail++; $display("FAIL single_write_drive: got %h want %h", {req_ready_a, sram_men, sram_wen, sram_ren, sram_addr}, {4'b1110, 10'd5}); end
    tick();
    idle(); req_valid_b = 1; req_we_b = 0; req_addr_b = 10'd5;
    @(negedge CLK);
    n_cmp++; if ({req_ready_b, sram_ren, sram_bm} !== {2'b11, 32'h0}) begin
      n_fail++; $display("FAIL single_read_drive: got %h want %h", {req_ready_b, sram_ren, sram_bm}, {2'b11, 32'h0}); end
    n_cmp++; if (rsp_valid_b !== 1'b0) begin n_fail++; $display("FAIL single_read_early: got %b want 0", rsp_valid_b); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if ({rsp_valid_b, rsp_rdata_b} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL single_read_rsp: got %h want %h", {rsp_valid_b, rsp_rdata_b}, {1'b1, 32'hDEADBEEF}); end
    tick();
  endtask

  task automatic test_byte_mask();
    req_valid_a = 1; req_we_a = 1; req_addr_a = 10'd5; req_wdata_a = 32'h11223344; req_bm_a = 32'h0000FFFF;
    @(negedge CLK);
    n_cmp++; if ({req_ready_a, sram_bm, sram_din} !== {1'b1, 32'h0000FFFF, 32'h11223344}) begin
      n_fail++; $display("FAIL bm_write_drive: got %h want %h", {req_ready_a, sram_bm, sram_din}, {1'b1, 32'h0000FFFF, 32'h11223344}); end
    tick();
    idle(); req_valid_a = 1; req_we_a = 0; req_addr_a = 10'd5;
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if ({rsp_valid_a, rsp_rdata_a} !== {1'b1, 32'hDEAD3344}) begin
      n_fail++; $display("FAIL bm_readback: got %h want %h", {rsp_valid_a, rsp_rdata_a}, {1'b1, 32'hDEAD3344}); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, prev_g;
    do_reset();
    req_valid_a = 1; req_we_a = 0; req_addr_a = 10'd1;
    req_valid_b = 1; req_we_b = 0; req_addr_b = 10'd2;
    prev_g = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
`ifdef SRAM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      n_cmp++; if ({req_ready_a, req_ready_b} !== exp_g) begin
        n_fail++; $display("FAIL contention_grant[%0d]: got %b want %b", i, {req_ready_a, req_ready_b}, exp_g); end
      n_cmp++; if ({rsp_valid_a, rsp_valid_b} !== prev_g) begin
        n_fail++; $display("FAIL contention_rsp[%0d]: got %b want %b", i, {rsp_valid_a, rsp_valid_b}, prev_g); end
      prev_g = exp_g;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid_a = 1; req_we_a = 1; req_addr_a = 10'd7; req_wdata_a = 32'hCAFE0007; req_bm_a = 32'hFFFFFFFF;
    tick();
    idle(); rsp_ready_b = 0; req_valid_b = 1; req_we_b = 0; req_addr_b = 10'd7;
    @(negedge CLK);
    n_cmp++; if (req_ready_b !== 1'b1) begin n_fail++; $display("FAIL bp_first_grant: got %b want 1", req_ready_b); end
    tick();
    req_addr_b = 10'd8;
    req_valid_a = 1; req_we_a = 0; req_addr_a = 10'd1; rsp_ready_a = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++; if ({rsp_valid_b, rsp_rdata_b} !== {1'b1, 32'hCAFE0007}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {rsp_valid_b, rsp_rdata_b}, {1'b1, 32'hCAFE0007}); end
      n_cmp++; if ({req_ready_a, req_ready_b} !== 2'b10) begin
        n_fail++; $display("FAIL bp_grants[%0d]: got %b want 10", i, {req_ready_a, req_ready_b}); end
      tick();
    end
    req_valid_a = 0; rsp_ready_b = 1;
    @(negedge CLK);
    n_cmp++; if ({req_ready_b, rsp_valid_b, rsp_rdata_b} !== {2'b01, 32'hCAFE0007}) begin
      n_fail++; $display("FAIL bp_drain: got %h want %h", {req_ready_b, rsp_valid_b, rsp_rdata_b}, {2'b01, 32'hCAFE0007}); end
    tick();
    @(negedge CLK);
    n_cmp++; if ({req_ready_b, rsp_valid_b} !== 2'b10) begin
      n_fail++; $display("FAIL bp_regrant: got %b want 10", {req_ready_b, rsp_valid_b}); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if (rsp_valid_b !== 1'b1) begin n_fail++; $display("FAIL bp_regrant_rsp: got %b want 1", rsp_valid_b); end
    tick();
  endtask

  task automatic test_write_during_hold();
    do_reset();
    req_valid_a = 1; req_we_a = 1; req_addr_a = 10'd9; req_wdata_a = 32'h5A5A0009; req_bm_a = 32'hFFFFFFFF;
    tick();
    idle(); rsp_ready_b = 0; req_valid_b = 1; req_we_b = 0; req_addr_b = 10'd9;
    tick();
    idle();
    tick();
    req_valid_b = 1; req_we_b = 1; req_addr_b = 10'd9; req_wdata_b = 32'h12345678; req_bm_b = 32'hFFFFFFFF;
    @(negedge CLK);
    n_cmp++; if ({req_ready_b, sram_wen, rsp_valid_b, rsp_rdata_b} !== {3'b111, 32'h5A5A0009}) begin
      n_fail++; $display("FAIL wdh_write_grant: got %h want %h", {req_ready_b, sram_wen, rsp_valid_b, rsp_rdata_b}, {3'b111, 32'h5A5A0009}); end
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if ({rsp_valid_b, rsp_rdata_b} !== {1'b1, 32'h5A5A0009}) begin
      n_fail++; $display("FAIL wdh_hold_stable: got %h want %h", {rsp_valid_b, rsp_rdata_b}, {1'b1, 32'h5A5A0009}); end
    rsp_ready_b = 1;
    tick();
    req_valid_b = 1; req_we_b = 0; req_addr_b = 10'd9;
    tick();
    idle();
    @(negedge CLK);
    n_cmp++; if ({rsp_valid_b, rsp_rdata_b} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL wdh_new_data: got %h want %h", {rsp_valid_b, rsp_rdata_b}, {1'b1, 32'h12345678}); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:15];
    bit          pend [2];
    logic [31:0] pdata [2];
    int          page [2];
    int          prefer;
    bit          v [2], we [2], rr [2], rd_ok [2], el [2];
    logic [9:0]  ad [2];
    logic [31:0] wd [2], bmv [2];
    int          g;
    logic [2:0]  exp_ctl;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      req_valid_a = 1; req_we_a = 1; req_addr_a = 10'(i); req_wdata_a = ref_mem[i]; req_bm_a = 32'hFFFFFFFF;
      @(negedge CLK);
      n_cmp++; if (req_ready_a !== 1'b1) begin n_fail++; $display("FAIL rnd_init_write[%0d]: got %b want 1", i, req_ready_a); end
      tick();
    end
    idle();
    prefer = 1;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; pdata[p] = '0; page[p] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        v[p]   = ($urandom_range(0, 9) < 6);
        we[p]  = ($urandom_range(0, 9) < 3);
        ad[p]  = 10'($urandom_range(0, 15));
        wd[p]  = $urandom;
        bmv[p] = $urandom_range(0, 1) ? 32'hFFFFFFFF : $urandom;
        rr[p]  = ($urandom_range(0, 9) < 7);
      end
      req_valid_a = v[0]; req_we_a = we[0]; req_addr_a = ad[0]; req_wdata_a = wd[0]; req_bm_a = bmv[0]; rsp_ready_a = rr[0];
      req_valid_b = v[1]; req_we_b = we[1]; req_addr_b = ad[1]; req_wdata_b = wd[1]; req_bm_b = bmv[1]; rsp_ready_b = rr[1];
      @(negedge CLK);
      for (int p = 0; p < 2; p++) begin
        rd_ok[p] = !pend[p] || (page[p] == 1 && rr[p]);
        el[p]    = v[p] && (we[p] || rd_ok[p]);
      end
      g = -1;
`ifdef SRAM_ARB_RR_EN
      if (el[0] && el[1]) g = prefer;
`else
      if (el[0] && el[1]) g = 0;
`endif
      else if (el[0]) g = 0;
      else if (el[1]) g = 1;
      n_cmp++; if ({req_ready_a, req_ready_b} !== {g == 0, g == 1}) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %b", cyc, {req_ready_a, req_ready_b}, {g == 0, g == 1}); end
      exp_ctl = (g < 0) ? 3'b000 : (we[g] ? 3'b110 : 3'b101);
      n_cmp++; if ({sram_men, sram_wen, sram_ren} !== exp_ctl) begin
        n_fail++; $display("FAIL rnd_sram_ctl[%0d]: got %b want %b", cyc, {sram_men, sram_wen, sram_ren}, exp_ctl); end
      if (g >= 0) begin
        n_cmp++; if (sram_addr !== ad[g]) begin
          n_fail++; $display("FAIL rnd_sram_addr[%0d]: got %h want %h", cyc, sram_addr, ad[g]); end
        n_cmp++; if (sram_bm !== (we[g] ? bmv[g] : 32'h0)) begin
          n_fail++; $display("FAIL rnd_sram_bm[%0d]: got %h want %h", cyc, sram_bm, we[g] ? bmv[g] : 32'h0); end
        if (we[g]) begin
          n_cmp++; if (sram_din !== wd[g]) begin
            n_fail++; $display("FAIL rnd_sram_din[%0d]: got %h want %h", cyc, sram_din, wd[g]); end
        end
      end
      n_cmp++; if (rsp_valid_a !== pend[0]) begin
        n_fail++; $display("FAIL rnd_rsp_valid_a[%0d]: got %b want %b", cyc, rsp_valid_a, pend[0]); end
      if (pend[0]) begin
        n_cmp++; if (rsp_rdata_a !== pdata[0]) begin
          n_fail++; $display("FAIL rnd_rdata_a[%0d]: got %h want %h", cyc, rsp_rdata_a, pdata[0]); end
      end
      n_cmp++; if (rsp_valid_b !== pend[1]) begin
        n_fail++; $display("FAIL rnd_rsp_valid_b[%0d]: got %b want %b", cyc, rsp_valid_b, pend[1]); end
      if (pend[1]) begin
        n_cmp++; if (rsp_rdata_b !== pdata[1]) begin
          n_fail++; $display("FAIL rnd_rdata_b[%0d]: got %h want %h", cyc, rsp_rdata_b, pdata[1]); end
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          if (rr[p]) pend[p] = 0;
          else       page[p] = page[p] + 1;
        end
      end
      if (g >= 0) begin
        if (we[g]) begin
          ref_mem[ad[g][3:0]] = (ref_mem[ad[g][3:0]] & ~bmv[g]) | (wd[g] & bmv[g]);
        end else begin
          pend[g]  = 1;
          pdata[g] = ref_mem[ad[g][3:0]];
          page[g]  = 1;
        end
        prefer = 1 - g;
      end
      tick();
    end
    idle();
    rsp_ready_a = 1;
    rsp_ready_b = 1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    RST_N = 0;
    idle();
    rsp_ready_a = 1;
    rsp_ready_b = 1;
    test_reset();
    test_single_read();
    test_byte_mask();
    test_contention();
    test_backpressure();
    test_write_during_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
